uart_rx_param: RTL and testbench

Parametrised RS-232 receiver and next-generation single-byte receive path. It takes the raw `rx` pin, synchronises it and detects start bits with false-start rejection. It samples a configurable-width frame at mid-bit under a run-time baud select and optional parity. It then presents each word with error flags on a valid/ready handshake to downstream logic (FIFO or command decoder).

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_param.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and baud helpers for the UART receive path.
// Divisors are rounded to the nearest clock count per bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_38400  = 38400;
  localparam int unsigned BAUD_115200 = 115200;

  function automatic logic [15:0] baud_div(
    input int unsigned clk_hz,
    input logic [1:0]  sel
  );
    int unsigned baud;
    int unsigned q;
    baud = BAUD_115200;
    case (sel)
      2'd0: baud = BAUD_9600;
      2'd1: baud = BAUD_19200;
      2'd2: baud = BAUD_38400;
      2'd3: baud = BAUD_115200;
      default: baud = BAUD_115200;
    endcase
    q = (clk_hz + baud / 2) / baud;
    return q[15:0];
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the rx pin, idle-high, with a
// falling-edge strobe taken on the synchronised signal.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic line,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
      last  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rx};
      last  <= chain[SYNC_STAGES-1];
    end
  end

  assign line = chain[SYNC_STAGES-1];
  assign fall = last & ~line;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output.
// Define UART_RX_PARITY_EN to receive and check a parity bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int          DATA_BITS   = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           baud_sel,
  input  logic                 rx,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [15:0] DIV0 = baud_div(CLK_HZ, 2'd0);
  localparam logic [15:0] DIV1 = baud_div(CLK_HZ, 2'd1);
  localparam logic [15:0] DIV2 = baud_div(CLK_HZ, 2'd2);
  localparam logic [15:0] DIV3 = baud_div(CLK_HZ, 2'd3);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  state_t               state;
  logic [15:0]          cnt;
  logic [15:0]          div;
  logic [15:0]          sel_div;
  logic [15:0]          div_m1;
  logic [15:0]          hdiv_m1;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 line;
  logic                 fall;
  logic                 accept;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .line(line),
    .fall(fall)
  );

  always_comb begin
    sel_div = DIV3;
    case (baud_sel)
      2'd0: sel_div = DIV0;
      2'd1: sel_div = DIV1;
      2'd2: sel_div = DIV2;
      2'd3: sel_div = DIV3;
      default: sel_div = DIV3;
    endcase
  end

  assign div_m1  = div - 16'd1;
  assign hdiv_m1 = (div >> 1) - 16'd1;
  // A held word can be replaced only when it is consumed this cycle.
  assign accept  = !rx_valid || rx_ready;

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_odd;
  assign parity_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= DIV0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            cnt     <= '0;
            bit_cnt <= '0;
            div     <= sel_div;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt == hdiv_m1) begin
            cnt <= '0;
            if (line) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == div_m1) begin
            cnt     <= '0;
            shreg   <= {line, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == div_m1) begin
            cnt       <= '0;
            par_err_q <= ^shreg ^ line ^ parity_odd;
            state     <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        // Leave at mid-stop so a back-to-back start edge is not missed.
        STOP: begin
          if (cnt == div_m1) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (accept) begin
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              frame_err  <= ~line;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_err_q;
`endif
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param against a
// frame-level model of the serial line and handshake.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ = 50_000_000;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] baud_sel = 2'd3;
  logic       rx = 1'b1;
  logic       parity_odd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  logic [1:0] baud_sel7 = 2'd0;
  logic       rx7 = 1'b1;
  logic       parity_odd7 = 1'b0;
  logic [6:0] rx_data7;
  logic       rx_valid7;
  logic       rx_ready7 = 1'b1;
  logic       frame_err7;
  logic       parity_err7;
  logic       overrun7;
  logic       busy7;

  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [7:0]  d;
    logic        fe;
    logic        pe;
    int unsigned cyc;
  } rec_t;
  rec_t got_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .DATA_BITS(8), .SYNC_STAGES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .baud_sel(baud_sel), .rx(rx),
    .parity_odd(parity_odd), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .DATA_BITS(7), .SYNC_STAGES(3)
  ) u_dut7 (
    .clk(clk), .rst(rst), .baud_sel(baud_sel7), .rx(rx7),
    .parity_odd(parity_odd7), .rx_data(rx_data7),
    .rx_valid(rx_valid7), .rx_ready(rx_ready7),
    .frame_err(frame_err7), .parity_err(parity_err7),
    .overrun(overrun7), .busy(busy7)
  );

  // Record every handshake completed on the 8-bit receiver.
  always begin
    @(negedge clk);
    #1;
    if (rx_valid && rx_ready)
      got_q.push_back('{rx_data, frame_err, parity_err, cyc});
    if (overrun) ovr_cnt++;
  end

  function automatic int unsigned div_of(input int sel);
    int unsigned baud;
    case (sel)
      0: baud = 9600;
      1: baud = 19200;
      2: baud = 38400;
      default: baud = 115200;
    endcase
    return (CLK_HZ + baud / 2) / baud;
  endfunction

  function automatic int unsigned lat_of(input int sel, input int nb, input int ss);
    int unsigned dv;
    dv = div_of(sel);
    return ss + 1 + dv / 2 + dv * (nb + P + 1);
  endfunction

  function automatic logic exp_pe(input logic [7:0] d, input logic pb, input logic po);
    return (P == 1) ? (^d ^ pb ^ po) : 1'b0;
  endfunction

  task automatic send_frame(input logic [7:0] d, input int sel,
                            input logic pb, input logic stop,
                            output int unsigned c0);
    int unsigned dv;
    dv = div_of(sel);
    @(negedge clk);
    baud_sel = 2'(sel);
    rx = 1'b0;
    c0 = cyc;
    repeat (dv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (dv) @(negedge clk);
    end
    if (P == 1) begin
      rx = pb;
      repeat (dv) @(negedge clk);
    end
    rx = stop;
    repeat (dv) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    int unsigned c0;
    rec_t r;
    repeat (3) @(negedge clk);
    tests++;
    if ({rx_data, rx_valid, frame_err, parity_err, overrun, busy} !== 13'd0 ||
        {rx_data7, rx_valid7, busy7} !== 9'd0) begin
      fails++;
      $display("FAIL reset_init: got %h/%b/%b want 0", rx_data, rx_valid, busy);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    baud_sel = 2'd3;
    rx = 1'b0;
    repeat (div_of(3) * 4) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy_mid: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({rx_data, rx_valid, frame_err, parity_err, overrun, busy} !== 13'd0) begin
      fails++;
      $display("FAIL reset_mid: got %h/%b/%b want 0", rx_data, rx_valid, busy);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 3, ^8'h81 ^ parity_odd, 1'b1, c0);
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL reset_count: got %0d words want 1", got_q.size());
      got_q.delete();
    end else begin
      r = got_q.pop_front();
      if (r.d !== 8'h81 || r.fe !== 1'b0 || r.pe !== 1'b0) begin
        fails++;
        $display("FAIL reset_word: got %h fe%b pe%b want 81", r.d, r.fe, r.pe);
      end
    end
  endtask

  task automatic test_baud_data;
    logic [7:0]  w [2];
    int unsigned c0 [2];
    int unsigned l;
    rec_t r;
    w[0] = 8'h55;
    w[1] = 8'hA3;
    parity_odd = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++)
      send_frame(w[i], 3, ^w[i], 1'b1, c0[i]);
    repeat (5) @(negedge clk);
    l = lat_of(3, 8, 2);
    tests++;
    if (got_q.size() != 2) begin
      fails++;
      $display("FAIL baud_count: got %0d words want 2", got_q.size());
      got_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        r = got_q.pop_front();
        tests++;
        if (r.d !== w[i] || r.fe !== 1'b0 || r.pe !== 1'b0) begin
          fails++;
          $display("FAIL baud_word%0d: got %h fe%b pe%b want %h", i, r.d, r.fe, r.pe, w[i]);
        end
        tests++;
        if (r.cyc - c0[i] + 1 < l || r.cyc - c0[i] > l + 1) begin
          fails++;
          $display("FAIL baud_lat%0d: got %0d want %0d", i, r.cyc - c0[i], l);
        end
      end
    end
  endtask

  task automatic test_baud_latch;
    int unsigned c0;
    rec_t r;
    fork
      send_frame(8'hC6, 3, ^8'hC6 ^ parity_odd, 1'b1, c0);
      begin
        repeat (1000) @(negedge clk);
        baud_sel = 2'd0;
      end
    join
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL latch_count: got %0d words want 1", got_q.size());
      got_q.delete();
    end else begin
      r = got_q.pop_front();
      if (r.d !== 8'hC6) begin
        fails++;
        $display("FAIL latch_word: got %h want c6", r.d);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0]  d;
    logic        pb;
    int unsigned c0;
    rec_t r;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      pb = 1'($urandom);
      parity_odd = 1'($urandom);
      send_frame(d, 3, pb, 1'b1, c0);
      repeat (5) @(negedge clk);
      tests++;
      if (got_q.size() != 1) begin
        fails++;
        $display("FAIL random_count%0d: got %0d want 1", k, got_q.size());
        got_q.delete();
      end else begin
        r = got_q.pop_front();
        if (r.d !== d || r.fe !== 1'b0 || r.pe !== exp_pe(d, pb, parity_odd)) begin
          fails++;
          $display("FAIL random_word%0d: got %h fe%b pe%b want %h pe%b",
                   k, r.d, r.fe, r.pe, d, exp_pe(d, pb, parity_odd));
        end
      end
    end
    parity_odd = 1'b0;
  endtask

  task automatic test_false_start;
    @(negedge clk);
    baud_sel = 2'd2;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL false_busy: got %b want 1", busy);
    end
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (560) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL false_idle: got busy %b want 0", busy);
    end
    repeat (2000) @(negedge clk);
    tests++;
    if (got_q.size() != 0 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL false_output: got %0d words want 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_framing;
    int unsigned c0;
    rec_t r;
    send_frame(8'h3C, 3, ^8'h3C ^ parity_odd, 1'b0, c0);
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL frame_count: got %0d want 1", got_q.size());
      got_q.delete();
    end else begin
      r = got_q.pop_front();
      if (r.d !== 8'h3C || r.fe !== 1'b1 || r.pe !== 1'b0) begin
        fails++;
        $display("FAIL frame_word: got %h fe%b pe%b want 3c fe1 pe0", r.d, r.fe, r.pe);
      end
    end
  endtask

  task automatic test_overrun;
    int unsigned c0;
    rec_t r;
    @(negedge clk);
    rx_ready = 1'b0;
    ovr_cnt = 0;
    send_frame(8'h12, 3, ^8'h12 ^ parity_odd, 1'b1, c0);
    send_frame(8'h34, 3, ^8'h34 ^ parity_odd, 1'b1, c0);
    repeat (5) @(negedge clk);
    tests++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h12 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL ovr_hold: got v%b %h want v1 12", rx_valid, rx_data);
    end
    tests++;
    if (ovr_cnt != 1 || got_q.size() != 0) begin
      fails++;
      $display("FAIL ovr_pulse: got %0d pulses %0d words want 1 0", ovr_cnt, got_q.size());
    end
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (got_q.size() != 1 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovr_drain: got %0d words v%b want 1 v0", got_q.size(), rx_valid);
      got_q.delete();
    end else begin
      r = got_q.pop_front();
      if (r.d !== 8'h12) begin
        fails++;
        $display("FAIL ovr_word: got %h want 12", r.d);
      end
    end
  endtask

  task automatic test_parity;
    logic        pb;
    int unsigned c0;
    rec_t r;
    parity_odd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pb = 1'(k);
      send_frame(8'h07, 3, pb, 1'b1, c0);
      repeat (5) @(negedge clk);
      tests++;
      if (got_q.size() != 1) begin
        fails++;
        $display("FAIL parity_count%0d: got %0d want 1", k, got_q.size());
        got_q.delete();
      end else begin
        r = got_q.pop_front();
        if (r.d !== 8'h07 || r.pe !== exp_pe(8'h07, pb, 1'b0)) begin
          fails++;
          $display("FAIL parity_word%0d: got %h pe%b want 07 pe%b",
                   k, r.d, r.pe, exp_pe(8'h07, pb, 1'b0));
        end
      end
    end
  endtask

  task automatic test_width_slow_baud;
    logic [6:0]  w;
    int unsigned dv;
    int unsigned c0;
    int unsigned lat;
    int unsigned l;
    bit          seen;
    logic [6:0]  got_d;
    logic        got_fe;
    logic        got_pe;
    w = 7'h5A;
    dv = div_of(0);
    l = lat_of(0, 7, 3);
    seen = 1'b0;
    lat = 0;
    got_d = '0;
    got_fe = 1'b0;
    got_pe = 1'b0;
    @(negedge clk);
    baud_sel7 = 2'd0;
    rx7 = 1'b0;
    c0 = cyc;
    repeat (dv) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx7 = w[i];
      repeat (dv) @(negedge clk);
    end
    if (P == 1) begin
      rx7 = ^w ^ parity_odd7;
      repeat (dv) @(negedge clk);
    end
    rx7 = 1'b1;
    for (int i = 0; i < int'(dv) && !seen; i++) begin
      @(negedge clk);
      if (rx_valid7) begin
        seen = 1'b1;
        got_d = rx_data7;
        got_fe = frame_err7;
        got_pe = parity_err7;
        lat = cyc - c0;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL width_timeout: got no word want 5a");
    end else begin
      if (got_d !== 7'h5A || got_fe !== 1'b0 || got_pe !== 1'b0) begin
        fails++;
        $display("FAIL width_word: got %h fe%b pe%b want 5a", got_d, got_fe, got_pe);
      end
      tests++;
      if (lat + 1 < l || lat > l + 1) begin
        fails++;
        $display("FAIL width_lat: got %0d want %0d", lat, l);
      end
    end
  endtask

  initial begin
    test_reset;
    fork
      test_width_slow_baud;
      begin
        test_baud_data;
        test_baud_latch;
        test_random;
        test_false_start;
        test_framing;
        test_overrun;
        test_parity;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
